fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction fetch/issue controller for the cute processor. Owns the program counter and reads 9-bit instructions from the registered instruction memory. Presents each instruction on DIN, pulses Run, waits for the processor's done, then advances or jumps. Replaces the ad-hoc Run/address glue around the ALU/mux PC path in the top level.

Parameters:
ADDR_W, 6, instruction memory address width / PC width
INSTR_W, 9, instruction width
PROG_LEN, 10, number of valid instruction words (addresses 0..PROG_LEN-1)
TIMEOUT, 64, max cycles in EXEC waiting for done before fault

Ports:
clk  input  1  clock, all state on posedge
Resetn  input  1  asynchronous, active-high reset
start  input  1  begin execution from address 0 (sampled in IDLE or HALT only)
mem_addr  output  ADDR_W  instruction memory read address
mem_rd  output  1  memory read strobe; data valid on mem_data the following cycle
mem_data  input  INSTR_W  instruction memory read data
DIN  output  INSTR_W  instruction to processor, registered
Run  output  1  one-cycle issue pulse to processor
done  input  1  processor finished current instruction
jmp  input  1  processor requests jump; valid only with done
bus  input  INSTR_W  processor bus; bits [ADDR_W-1:0] are the jump target
pc  output  ADDR_W  current program counter
busy  output  1  high in FETCH/WAIT/ISSUE/EXEC
halted  output  1  high in HALT
err  output  2  fault cause: 00 none, 01 jump out of range, 10 timeout
retired  output  8  instructions completed since start, saturates at 255

Behaviour:
- Reset (async, Resetn=1): state=IDLE. pc=0, mem_addr=0, mem_rd=0, DIN=0, Run=0, busy=0, halted=0, err=00, retired=0, watchdog=0.
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALT.
- IDLE: start=1 -> FETCH with pc=0, retired=0, err=00.
- FETCH (1 cycle): mem_addr=pc, mem_rd=1 -> WAIT.
- WAIT (1 cycle): mem_rd=0. DIN<=mem_data at the end of the cycle -> ISSUE.
- ISSUE (1 cycle): Run=1, DIN stable. done is ignored here. Watchdog cleared -> EXEC.
- EXEC: Run=0, DIN held. Watchdog increments each cycle.
  - done=1 and jmp=1: target=bus[ADDR_W-1:0].
    - target<PROG_LEN -> pc<=target, FETCH.
    - else pc unchanged, err=01, HALT.
  - done=1 and jmp=0:
    - pc==PROG_LEN-1 -> HALT, err=00 (normal end), pc unchanged.
    - else pc<=pc+1, FETCH.
  - Any done in EXEC increments retired (saturating), including the one that causes HALT.
  - done=0 and watchdog reaches TIMEOUT-1 -> HALT, err=10.
  - jmp without done is ignored.
- HALT: halted=1, busy=0, pc/err/retired held. start=1 -> FETCH with pc=0, err=00, retired=0.
- Latency: start sampled at T0 -> FETCH T1 -> WAIT T2 -> ISSUE T3 (Run=1). Done at Tn -> next Run at Tn+3.
- start while busy: ignored.
- Reset mid-operation: immediate return to IDLE with all reset values. Run deasserts asynchronously.
- PC arithmetic is ADDR_W-bit unsigned. The PROG_LEN check precedes any increment, so pc never wraps.

Test Plan:
- Straight-line: PROG_LEN=10, done 2 cycles after each Run -> mem_addr 0..9 in order, Run at T3 then every 5 cycles, HALT after 10th done, err=00, retired=10, pc=9.
- Jump: at pc=3, done=1 with jmp=1, bus=9'h005 -> next mem_addr=5, address 4 never fetched, retired counts normally.
- Bad jump: done=1, jmp=1, bus[5:0]=12 -> HALT, err=01, pc stays 3, no further mem_rd.
- Timeout: withhold done after Run -> HALT exactly TIMEOUT cycles after entering EXEC, err=10, retired unchanged.
- Reset mid-EXEC: assert Resetn between clock edges while Run is pending -> outputs reach reset values immediately. Restart with start -> fetch from address 0.
- Restart and ignore: start pulsed during EXEC has no effect. start in HALT -> err cleared, retired=0, mem_addr=0 on the next cycle.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and processor-side signals of the fetch sequencer.
//
// Handshake semantics:
//   Memory: the sequencer drives mem_addr with mem_rd=1 for one cycle; the
//   registered memory returns the word on mem_data in the following cycle.
//   Processor: Run is a one-cycle issue pulse, with DIN valid from the Run
//   cycle until the next fetch. The processor answers with a one-cycle done
//   pulse. done is ignored in the Run cycle itself. jmp and bus are
//   meaningful only in a cycle where done=1. Otherwise they are don't-care.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 9
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] mem_data;
  logic [INSTR_W-1:0] DIN;
  logic               Run;
  logic               done;
  logic               jmp;
  logic [INSTR_W-1:0] bus;

  modport master (
    output mem_addr, mem_rd, DIN, Run,
    input  mem_data, done, jmp, bus
  );

  modport slave (
    input  mem_addr, mem_rd, DIN, Run,
    output mem_data, done, jmp, bus
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller. It owns the PC and reads one word from
// the registered instruction memory. It issues the word to the processor with
// a Run pulse, then waits for done and either advances, jumps or halts. A
// watchdog stops the machine if the processor never answers.
module fetch_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int INSTR_W  = 9,
  parameter int PROG_LEN = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              start,
  fetch_sequencer_if.master pif,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        err,
  output logic [7:0]        retired,
  output logic [2:0]        dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   LP_WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LP_LAST     = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   LP_LEN_EXT  = (ADDR_W + 1)'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_rd;
  logic [INSTR_W-1:0] r_din;
  logic               r_run;
  logic               r_busy;
  logic               r_halted;
  logic [1:0]         r_err;
  logic [7:0]         r_retired;
  logic [WD_W-1:0]    r_wd;

  logic [ADDR_W-1:0]  w_target;
  logic               w_target_ok;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_unused_bus_hi;

  // Jump target decode and sequential PC. The PROG_LEN check is made before
  // the increment is used, so the PC never wraps.
  assign w_target        = pif.bus[ADDR_W-1:0];
  assign w_target_ok     = ({1'b0, w_target} < LP_LEN_EXT);
  assign w_pc_inc        = r_pc + 1'b1;
  assign w_unused_bus_hi = ^pif.bus[INSTR_W-1:ADDR_W];

  // Sequencer FSM; every output is a register updated with the state.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_din      <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 2'b00;
      r_retired  <= '0;
      r_wd       <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_run    <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b1;
            r_err      <= 2'b00;
            r_retired  <= '0;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_din   <= pif.mem_data;
          r_run   <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (pif.done) begin
            if (r_retired != 8'hFF) r_retired <= r_retired + 8'd1;
            if (pif.jmp) begin
              if (w_target_ok) begin
                r_pc       <= w_target;
                r_mem_addr <= w_target;
                r_mem_rd   <= 1'b1;
                r_state    <= S_FETCH;
              end else begin
                r_err    <= 2'b01;
                r_busy   <= 1'b0;
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end
            end else if (r_pc == LP_LAST) begin
              r_err    <= 2'b00;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_pc       <= w_pc_inc;
              r_mem_addr <= w_pc_inc;
              r_mem_rd   <= 1'b1;
              r_state    <= S_FETCH;
            end
          end else if (r_wd == LP_WD_LAST) begin
            r_err    <= 2'b10;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: begin
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign pif.mem_addr = r_mem_addr;
  assign pif.mem_rd   = r_mem_rd;
  assign pif.DIN      = r_din;
  assign pif.Run      = r_run;
  assign pc           = r_pc;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign err          = r_err;
  assign retired      = r_retired;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a registered ROM model, a processor responder
// driven from a per-test response plan, a reference model that walks the
// program from the sequencing rules, and a Run monitor with an expected queue.
module tb_fetch_sequencer;

  localparam int ADDR_W   = 6;
  localparam int INSTR_W  = 9;
  localparam int PROG_LEN = 10;
  localparam int TIMEOUT  = 64;
  localparam int EW       = 32 + ADDR_W + INSTR_W;

  localparam int M_STRAIGHT = 0;
  localparam int M_JUMP     = 1;
  localparam int M_BADJMP   = 2;
  localparam int M_TIMEOUT  = 3;
  localparam int M_RAND     = 4;
  localparam int M_SAT      = 5;

  logic clk = 1'b0;
  logic Resetn = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic busy, halted;
  logic [1:0] err;
  logic [7:0] retired;
  logic [2:0] dbg_state;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) pif ();

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PROG_LEN(PROG_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .Resetn(Resetn), .start(start), .pif(pif),
    .pc(pc), .busy(busy), .halted(halted), .err(err),
    .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  logic [INSTR_W-1:0] rom [0:63];
  int                 resp_d     [0:511];
  bit                 resp_j     [0:511];
  logic [INSTR_W-1:0] resp_bus   [0:511];
  bit                 resp_ghost [0:511];
  int run_idx = 0;
  int resp_k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Registered instruction memory: data appears the cycle after mem_rd.
  always @(posedge clk) if (pif.mem_rd) pif.mem_data <= rom[pif.mem_addr];

  // ---------------- processor responder ----------------
  initial begin
    pif.done = 1'b0;
    pif.jmp  = 1'b0;
    pif.bus  = '0;
    forever begin
      @(negedge clk);
      if (pif.Run === 1'b1 && Resetn == 1'b0) begin
        resp_k = run_idx;
        run_idx++;
        if (resp_ghost[resp_k]) begin
          pif.done = 1'b1;
          pif.jmp  = 1'($urandom);
          pif.bus  = INSTR_W'($urandom);
        end
        if (resp_d[resp_k] == 0) begin
          @(posedge clk); #1;
          pif.done = 1'b0;
          pif.jmp  = 1'b0;
        end else begin
          for (int i = 1; i <= resp_d[resp_k]; i++) begin
            @(posedge clk); #1;
            if (i == resp_d[resp_k]) begin
              pif.done = 1'b1;
              pif.jmp  = resp_j[resp_k];
              pif.bus  = resp_bus[resp_k];
            end else begin
              pif.done = 1'b0;
              pif.jmp  = 1'($urandom);
              pif.bus  = INSTR_W'($urandom);
            end
          end
          @(posedge clk); #1;
          pif.done = 1'b0;
          pif.jmp  = 1'b0;
        end
      end
    end
  end

  // ---------------- Run monitor ----------------
  logic [ADDR_W-1:0] last_fetch = '0;
  logic [EW-1:0]     mon_exp;
  always @(negedge clk) begin
    if (pif.mem_rd === 1'b1) last_fetch = pif.mem_addr;
    if (pif.Run === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_run", {32'(cyc), last_fetch, pif.DIN}, '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("run_cycle_addr_instr", 64'({32'(cyc), last_fetch, pif.DIN}), 64'(mon_exp));
        check("pc_at_issue", 64'(pc), 64'(mon_exp[INSTR_W +: ADDR_W]));
      end
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic run_test(input int mode, input int n_max);
    int p, ret, e, k, d, s, t, halt_t;
    bit j, fin, jumped, seen;
    logic [ADDR_W-1:0] tg;
    for (int a = 0; a < 64; a++) rom[a] = INSTR_W'($urandom);
    @(posedge clk); #1;
    run_idx = 0;
    s = cyc;
    p = 0; ret = 0; e = 0; k = 0; t = s + 3; fin = 0; jumped = 0; halt_t = 0;
    while (!fin) begin
      exp_q.push_back({32'(t), ADDR_W'(p), rom[p]});
      d = 2; j = 0; tg = '0;
      resp_ghost[k] = 0;
      case (mode)
        M_JUMP:    begin d = $urandom_range(1, 3); if (p == 3 && !jumped) begin j = 1; tg = 5; jumped = 1; end end
        M_BADJMP:  begin if (p == 3) begin j = 1; tg = 12; end end
        M_TIMEOUT: begin if (p == 2) d = 0; end
        M_RAND: begin
          d = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 4);
          j = ($urandom_range(0, 3) == 0);
          tg = ADDR_W'($urandom_range(0, 15));
          resp_ghost[k] = ($urandom_range(0, 3) == 0);
        end
        M_SAT: begin d = 1; if (p == 2) begin j = 1; tg = 0; end end
        default: ;
      endcase
      if (k >= n_max - 1 && d != 0) begin
        j = 1;
        tg = ADDR_W'($urandom_range(PROG_LEN, 63));
      end
      resp_d[k]   = d;
      resp_j[k]   = j;
      resp_bus[k] = {3'($urandom), tg};
      if (d == 0) begin
        e = 2; halt_t = t + 1 + TIMEOUT; fin = 1;
      end else begin
        if (ret < 255) ret++;
        if (j && int'(tg) < PROG_LEN) begin
          p = int'(tg); t = t + d + 3;
        end else if (j) begin
          e = 1; halt_t = t + d + 1; fin = 1;
        end else if (p == PROG_LEN - 1) begin
          e = 0; halt_t = t + d + 1; fin = 1;
        end else begin
          p++; t = t + d + 3;
        end
      end
      k++;
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_mem_addr", 64'(pif.mem_addr), 64'(0));
    check("start_mem_rd", 64'(pif.mem_rd), 64'(1));
    check("start_err_clear", 64'(err), 64'(0));
    check("start_retired_clear", 64'(retired), 64'(0));
    check("start_busy", 64'({busy, halted}), 64'(2'b10));

    seen = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (halted === 1'b1) begin seen = 1; break; end
      if (busy === 1'b1 && (c % 7) == 3) start = 1'b1;
    end
    start = 1'b0;
    check("halt_reached", 64'(seen), 64'(1));
    check("halt_cycle", 64'(cyc), 64'(halt_t));
    check("final_pc", 64'(pc), 64'(p));
    check("final_err", 64'(err), 64'(e));
    check("final_retired", 64'(retired), 64'(ret));
    check("final_busy", 64'(busy), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pif.mem_rd !== 1'b0) seen = 1;
    end
    check("no_mem_rd_in_halt", 64'(seen), 64'(0));
  endtask

  task automatic reset_test();
    int s;
    bit seen;
    for (int a = 0; a < 64; a++) rom[a] = INSTR_W'($urandom);
    @(posedge clk); #1;
    run_idx = 0;
    s = cyc;
    exp_q.push_back({32'(s + 3), ADDR_W'(0), rom[0]});
    resp_d[0] = 0;
    resp_ghost[0] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pif.Run === 1'b1) begin seen = 1; break; end
    end
    check("reset_test_run_seen", 64'(seen), 64'(1));
    #2 Resetn = 1'b1;
    #1;
    check("async_rst_run", 64'(pif.Run), 64'(0));
    check("async_rst_pc_addr_rd", 64'({pc, pif.mem_addr, pif.mem_rd}), 64'(0));
    check("async_rst_din", 64'(pif.DIN), 64'(0));
    check("async_rst_status", 64'({busy, halted, err, retired}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    Resetn = 1'b0;
    check("reset_queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      resp_d[i] = 1; resp_j[i] = 0; resp_bus[i] = '0; resp_ghost[i] = 0;
    end
    for (int a = 0; a < 64; a++) rom[a] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pc_addr_rd", 64'({pc, pif.mem_addr, pif.mem_rd}), 64'(0));
    check("reset_din_run", 64'({pif.DIN, pif.Run}), 64'(0));
    check("reset_status", 64'({busy, halted, err, retired}), 64'(0));
    @(posedge clk); #1;
    Resetn = 1'b0;

    run_test(M_STRAIGHT, 40);
    run_test(M_JUMP, 40);
    run_test(M_BADJMP, 40);
    run_test(M_TIMEOUT, 40);
    reset_test();
    for (int n = 0; n < 6; n++) run_test(M_RAND, 40);
    run_test(M_SAT, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
